// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle
//
// Multicycle control unit for the 16-bit bus-based processor. A 2-bit step
// counter (T0..T3) sequences each instruction held in the IR. Every output is
// combinational from the step, the IR, run and g_nz, and the datapath latches
// on the falling edge, so enables and selects settle for half a period before
// use. At most one source drives the shared bus in any cycle, and exactly one
// drives it whenever any register loads.
//
// Ports:
//   clock    rising-edge clock for the step counter
//   reset    synchronous, active-high; forces all outputs low, returns to T0
//   run      start request, only looked at in T0
//   ir       instruction: opcode ir[15:12], rx ir[11:9], ry ir[8:6]
//   g_nz     G register is non-zero (condition for mvnz)
//   ir_in    IR write enable
//   r_in     one-hot write enables for R0..R7
//   r_out    one-hot bus selects for R0..R7
//   g_out    bus select for G
//   din_out  bus select for external DIN
//   a_in     A write enable
//   g_in     G write enable
//   alu_op   00 add, 01 sub, 10 and, 11 slt
//   addr_in  ADDR write enable
//   dout_in  DOUT write enable
//   w_d      memory write strobe
//   done     last step of the current instruction
// -----------------------------------------------------------------------------
module unidade_controle (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic        g_nz,
    output logic        ir_in,
    output logic [7:0]  r_in,
    output logic [7:0]  r_out,
    output logic        g_out,
    output logic        din_out,
    output logic        a_in,
    output logic        g_in,
    output logic [1:0]  alu_op,
    output logic        addr_in,
    output logic        dout_in,
    output logic        w_d,
    output logic        done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam logic [3:0] OP_MV   = 4'h0;
    localparam logic [3:0] OP_MVI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_MVNZ = 4'h8;

    step_t      step;
    step_t      next_step;

    logic [3:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] sel_rx;
    logic [7:0] sel_ry;
    logic [3:0] alu_sel;
    logic       is_alu;

    assign opcode  = ir[15:12];
    assign rx      = ir[11:9];
    assign ry      = ir[8:6];
    assign sel_rx  = 8'd1 << rx;
    assign sel_ry  = 8'd1 << ry;
    // ALU opcodes 0010..0101 map onto alu_op 00..11.
    assign alu_sel = opcode - 4'd2;
    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_SLT);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values of its inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            step <= T0;
        end else begin
            step <= next_step;
        end
    end

    always_comb begin
        // NOTE: every output and next_step gets a default first, so no path
        // through the case statements can leave one unassigned (no latches).
        next_step = step;
        ir_in     = 1'b0;
        r_in      = '0;
        r_out     = '0;
        g_out     = 1'b0;
        din_out   = 1'b0;
        a_in      = 1'b0;
        g_in      = 1'b0;
        alu_op    = 2'b00;
        addr_in   = 1'b0;
        dout_in   = 1'b0;
        w_d       = 1'b0;
        done      = 1'b0;

        // Reset masks every output in the same cycle, so an aborted
        // instruction cannot leave a final write pulse behind.
        if (!reset) begin
            unique case (step)
                T0: begin
                    ir_in = run;
                    if (run) begin
                        next_step = T1;
                    end
                end

                T1: begin
                    next_step = T2;
                    if (opcode == OP_MV) begin
                        r_out = sel_ry;
                        r_in  = sel_rx;
                        done  = 1'b1;
                    end else if (opcode == OP_MVI) begin
                        din_out = 1'b1;
                        r_in    = sel_rx;
                        done    = 1'b1;
                    end else if (is_alu) begin
                        r_out = sel_rx;
                        a_in  = 1'b1;
                    end else if (opcode == OP_LD || opcode == OP_ST) begin
                        r_out   = sel_ry;
                        addr_in = 1'b1;
                    end else if (opcode == OP_MVNZ) begin
                        done = 1'b1;
                        if (g_nz) begin
                            r_out = sel_ry;
                            r_in  = sel_rx;
                        end
                    end else begin
                        done = 1'b1;
                    end
                end

                T2: begin
                    next_step = T3;
                    if (is_alu) begin
                        r_out  = sel_ry;
                        g_in   = 1'b1;
                        alu_op = alu_sel[1:0];
                    end else if (opcode == OP_ST) begin
                        r_out   = sel_rx;
                        dout_in = 1'b1;
                        w_d     = 1'b1;
                        done    = 1'b1;
                    end else if (opcode != OP_LD) begin
                        // Not reachable for a stable IR; recover to T0.
                        next_step = T0;
                    end
                end

                T3: begin
                    next_step = T0;
                    if (is_alu) begin
                        g_out = 1'b1;
                        r_in  = sel_rx;
                        done  = 1'b1;
                    end else if (opcode == OP_LD) begin
                        din_out = 1'b1;
                        r_in    = sel_rx;
                        done    = 1'b1;
                    end
                end
            endcase

            if (done) begin
                next_step = T0;
            end
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle
//
// Directed-vector bench for unidade_controle. Each cycle's inputs are applied
// on the falling edge and the combinational outputs are compared 1 ns later,
// well away from the rising edge that advances the step counter.
// -----------------------------------------------------------------------------
module tb_unidade_controle;

    logic        clock;
    logic        reset;
    logic        run;
    logic [15:0] ir;
    logic        g_nz;
    logic        ir_in;
    logic [7:0]  r_in;
    logic [7:0]  r_out;
    logic        g_out;
    logic        din_out;
    logic        a_in;
    logic        g_in;
    logic [1:0]  alu_op;
    logic        addr_in;
    logic        dout_in;
    logic        w_d;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       ir_in;
        logic [7:0] r_in;
        logic [7:0] r_out;
        logic       g_out;
        logic       din_out;
        logic       a_in;
        logic       g_in;
        logic [1:0] alu_op;
        logic       addr_in;
        logic       dout_in;
        logic       w_d;
        logic       done;
    } ctrl_t;

    typedef struct {
        logic        rst;
        logic        run;
        logic [15:0] ir;
        logic        gnz;
        ctrl_t       exp;
    } vec_t;

    localparam logic [8:0] NONE = 9'h000;
    localparam logic [8:0] IRIN = 9'h100;
    localparam logic [8:0] GOUT = 9'h080;
    localparam logic [8:0] DIN  = 9'h040;
    localparam logic [8:0] AIN  = 9'h020;
    localparam logic [8:0] GIN  = 9'h010;
    localparam logic [8:0] ADDR = 9'h008;
    localparam logic [8:0] DOUT = 9'h004;
    localparam logic [8:0] WD   = 9'h002;
    localparam logic [8:0] DONE = 9'h001;

    unidade_controle dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .ir      (ir),
        .g_nz    (g_nz),
        .ir_in   (ir_in),
        .r_in    (r_in),
        .r_out   (r_out),
        .g_out   (g_out),
        .din_out (din_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .alu_op  (alu_op),
        .addr_in (addr_in),
        .dout_in (dout_in),
        .w_d     (w_d),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic ctrl_t ex(input logic [7:0] rin, input logic [7:0] rout,
                                 input logic [8:0] f, input logic [1:0] alu);
        ctrl_t e;
        e.ir_in   = f[8];
        e.r_in    = rin;
        e.r_out   = rout;
        e.g_out   = f[7];
        e.din_out = f[6];
        e.a_in    = f[5];
        e.g_in    = f[4];
        e.alu_op  = alu;
        e.addr_in = f[3];
        e.dout_in = f[2];
        e.w_d     = f[1];
        e.done    = f[0];
        return e;
    endfunction

    function automatic vec_t v(input logic v_rst, input logic v_run,
                               input logic [15:0] v_ir, input logic v_gnz,
                               input ctrl_t v_exp);
        vec_t x;
        x.rst = v_rst;
        x.run = v_run;
        x.ir  = v_ir;
        x.gnz = v_gnz;
        x.exp = v_exp;
        return x;
    endfunction

    function automatic ctrl_t cur();
        return {ir_in, r_in, r_out, g_out, din_out, a_in, g_in, alu_op,
                addr_in, dout_in, w_d, done};
    endfunction

    task automatic drive(input vec_t x);
        @(negedge clock);
        reset = x.rst;
        run   = x.run;
        ir    = x.ir;
        g_nz  = x.gnz;
        #1;
    endtask

    task automatic test_reset();
        vec_t q[$];
        q.push_back(v(1, 1, 16'hF000, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        q.push_back(v(1, 0, 16'hF000, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        for (int k = 0; k < 5; k++)
            q.push_back(v(0, 0, 16'hF000, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        q.push_back(v(0, 1, 16'hF000, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 0, 16'hF000, 0, ex(8'h00, 8'h00, DONE, 2'b00)));
        q.push_back(v(0, 0, 16'hF000, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (cur() !== q[i].exp) begin
                errors++;
                $display("FAIL reset[%0d] got %h expected %h", i, cur(), q[i].exp);
            end
        end
    endtask

    task automatic test_mvi_mv();
        vec_t q[$];
        q.push_back(v(0, 1, 16'h1400, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 1, 16'h1400, 0, ex(8'h04, 8'h00, DIN | DONE, 2'b00)));
        q.push_back(v(0, 1, 16'h0A80, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 0, 16'h0A80, 0, ex(8'h20, 8'h04, DONE, 2'b00)));
        q.push_back(v(0, 0, 16'h0A80, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (cur() !== q[i].exp) begin
                errors++;
                $display("FAIL mvi_mv[%0d] got %h expected %h", i, cur(), q[i].exp);
            end
        end
    endtask

    task automatic test_alu();
        vec_t q[$];
        // add R1,R3 ; slt R1,R3 ; and R1,R3 -- run toggled outside T0 must not matter
        q.push_back(v(0, 1, 16'h22C0, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 0, 16'h22C0, 0, ex(8'h00, 8'h02, AIN, 2'b00)));
        q.push_back(v(0, 1, 16'h22C0, 0, ex(8'h00, 8'h08, GIN, 2'b00)));
        q.push_back(v(0, 0, 16'h22C0, 0, ex(8'h02, 8'h00, GOUT | DONE, 2'b00)));
        q.push_back(v(0, 1, 16'h52C0, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 1, 16'h52C0, 0, ex(8'h00, 8'h02, AIN, 2'b00)));
        q.push_back(v(0, 0, 16'h52C0, 0, ex(8'h00, 8'h08, GIN, 2'b11)));
        q.push_back(v(0, 0, 16'h52C0, 0, ex(8'h02, 8'h00, GOUT | DONE, 2'b00)));
        q.push_back(v(0, 1, 16'h42C0, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 0, 16'h42C0, 0, ex(8'h00, 8'h02, AIN, 2'b00)));
        q.push_back(v(0, 0, 16'h42C0, 0, ex(8'h00, 8'h08, GIN, 2'b10)));
        q.push_back(v(0, 0, 16'h42C0, 0, ex(8'h02, 8'h00, GOUT | DONE, 2'b00)));
        q.push_back(v(0, 0, 16'h42C0, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (cur() !== q[i].exp) begin
                errors++;
                $display("FAIL alu[%0d] got %h expected %h", i, cur(), q[i].exp);
            end
        end
    endtask

    task automatic test_ld_st();
        vec_t q[$];
        q.push_back(v(0, 1, 16'h6980, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 0, 16'h6980, 0, ex(8'h00, 8'h40, ADDR, 2'b00)));
        q.push_back(v(0, 1, 16'h6980, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        q.push_back(v(0, 0, 16'h6980, 0, ex(8'h10, 8'h00, DIN | DONE, 2'b00)));
        q.push_back(v(0, 1, 16'h7980, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 0, 16'h7980, 0, ex(8'h00, 8'h40, ADDR, 2'b00)));
        q.push_back(v(0, 0, 16'h7980, 0, ex(8'h00, 8'h10, DOUT | WD | DONE, 2'b00)));
        q.push_back(v(0, 0, 16'h7980, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (cur() !== q[i].exp) begin
                errors++;
                $display("FAIL ld_st[%0d] got %h expected %h", i, cur(), q[i].exp);
            end
        end
    endtask

    task automatic test_mvnz();
        vec_t q[$];
        q.push_back(v(0, 1, 16'h81C0, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 0, 16'h81C0, 0, ex(8'h00, 8'h00, DONE, 2'b00)));
        q.push_back(v(0, 1, 16'h81C0, 1, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 0, 16'h81C0, 1, ex(8'h01, 8'h80, DONE, 2'b00)));
        q.push_back(v(0, 0, 16'h81C0, 1, ex(8'h00, 8'h00, NONE, 2'b00)));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (cur() !== q[i].exp) begin
                errors++;
                $display("FAIL mvnz[%0d] got %h expected %h", i, cur(), q[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t q[$];
        // mv R3,R3 ; NOP ; st R4,[R6] with run held high throughout
        q.push_back(v(0, 1, 16'h06C0, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 1, 16'h06C0, 0, ex(8'h08, 8'h08, DONE, 2'b00)));
        q.push_back(v(0, 1, 16'h9FFF, 1, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 1, 16'h9FFF, 1, ex(8'h00, 8'h00, DONE, 2'b00)));
        q.push_back(v(0, 1, 16'h7980, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 1, 16'h7980, 0, ex(8'h00, 8'h40, ADDR, 2'b00)));
        q.push_back(v(0, 1, 16'h7980, 0, ex(8'h00, 8'h10, DOUT | WD | DONE, 2'b00)));
        q.push_back(v(0, 0, 16'h7980, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (cur() !== q[i].exp) begin
                errors++;
                $display("FAIL back_to_back[%0d] got %h expected %h", i, cur(), q[i].exp);
            end
        end
    endtask

    task automatic test_reset_abort();
        vec_t q[$];
        // sub R1,R3 aborted in T2, then rerun from a clean T0
        q.push_back(v(0, 1, 16'h32C0, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 0, 16'h32C0, 0, ex(8'h00, 8'h02, AIN, 2'b00)));
        q.push_back(v(1, 1, 16'h32C0, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        q.push_back(v(0, 0, 16'h32C0, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        q.push_back(v(0, 0, 16'h32C0, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        q.push_back(v(0, 1, 16'h32C0, 0, ex(8'h00, 8'h00, IRIN, 2'b00)));
        q.push_back(v(0, 0, 16'h32C0, 0, ex(8'h00, 8'h02, AIN, 2'b00)));
        q.push_back(v(0, 0, 16'h32C0, 0, ex(8'h00, 8'h08, GIN, 2'b01)));
        q.push_back(v(0, 0, 16'h32C0, 0, ex(8'h02, 8'h00, GOUT | DONE, 2'b00)));
        q.push_back(v(0, 0, 16'h32C0, 0, ex(8'h00, 8'h00, NONE, 2'b00)));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (cur() !== q[i].exp) begin
                errors++;
                $display("FAIL reset_abort[%0d] got %h expected %h", i, cur(), q[i].exp);
            end
        end
    endtask

    task automatic test_random_bus();
        int          n;
        int          lat;
        int          bus;
        logic        loads;
        logic        seen_done;
        logic [3:0]  op;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            reset = 1'b0;
            run   = 1'b1;
            ir    = 16'($urandom);
            g_nz  = 1'($urandom_range(0, 1));
            #1;
            op  = ir[15:12];
            lat = (op >= 4'h2 && op <= 4'h6) ? 4 : (op == 4'h7) ? 3 : 2;
            n   = 1;
            checks++;
            if (ir_in !== 1'b1) begin
                errors++;
                $display("FAIL rand_t0[%0d] ir_in got %b expected 1", k, ir_in);
            end
            seen_done = 1'b0;
            while (!seen_done && n < 8) begin
                @(negedge clock);
                #1;
                n++;
                bus   = $countones(r_out) + int'(g_out) + int'(din_out);
                loads = (|r_in) | a_in | g_in | addr_in | dout_in;
                checks++;
                if (bus > 1 || (loads && bus != 1)) begin
                    errors++;
                    $display("FAIL rand_bus[%0d] ir %h drivers got %0d loads %b expected one driver when loading",
                             k, ir, bus, loads);
                end
                seen_done = done;
            end
            checks++;
            if (n != lat) begin
                errors++;
                $display("FAIL rand_latency[%0d] ir %h cycles got %0d expected %0d", k, ir, n, lat);
                break;
            end
        end
        @(negedge clock);
        run = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        ir    = 16'h0000;
        g_nz  = 1'b0;
        test_reset();
        test_mvi_mv();
        test_alu();
        test_ld_st();
        test_mvnz();
        test_back_to_back();
        test_reset_abort();
        test_random_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit for the 16-bit bus-based processor datapath. It decodes the instruction held in the IR and, one timestep per clock, drives the write enables of the R0–R7/A/G/IR/ADDR/DOUT registers and the select lines of the shared 16-bit bus. It guarantees that exactly one source drives the bus in any cycle where a register loads. It is the only block that sequences the register file.

## Interface
Parameters:
- none; widths fixed: data 16 bits, 8 general registers, 4-bit opcode.

Ports:
- clock  in  1  system clock; FSM advances on rising edge
- reset  in  1  synchronous, active-high; returns FSM to T0
- run  in  1  start request; sampled in T0
- ir  in  16  current instruction, output of the IR register; opcode ir[15:12], rx ir[11:9], ry ir[8:6]
- g_nz  in  1  1 when the G register is non-zero
- ir_in  out  1  IR write enable
- r_in  out  8  one-hot write enables, R0..R7
- r_out  out  8  one-hot bus select, R0..R7
- g_out  out  1  bus select, G
- din_out  out  1  bus select, external DIN
- a_in  out  1  A write enable
- g_in  out  1  G write enable
- alu_op  out  2  00 add, 01 sub, 10 and, 11 slt (signed, result 16'd1/16'd0)
- addr_in  out  1  ADDR write enable
- dout_in  out  1  DOUT write enable
- w_d  out  1  memory write strobe
- done  out  1  last timestep of the current instruction

## Operation
- States: T0, T1, T2, T3 (2-bit step counter). All outputs combinational from state, ir, run and g_nz. Any output not listed for a step is 0.
- T0: ir_in = run. If run=1, go to T1; otherwise stay in T0.
- mv (0000): T1: r_out[ry], r_in[rx], done.
- mvi (0001): T1: din_out, r_in[rx], done. The immediate is on DIN during this cycle.
- add/sub/and/slt (0010/0011/0100/0101): T1: r_out[rx], a_in. T2: r_out[ry], g_in, alu_op = opcode−2. T3: g_out, r_in[rx], done.
- ld (0110): T1: r_out[ry], addr_in. T2: no outputs (memory access cycle). T3: din_out, r_in[rx], done.
- st (0111): T1: r_out[ry], addr_in. T2: r_out[rx], dout_in, w_d, done.
- mvnz (1000): T1: done. If g_nz=1, also r_out[ry] and r_in[rx]. If g_nz=0, no register is written.
- Opcodes 1001–1111: T1: done only (NOP).
- A step with done=1 always goes to T0 on the next edge. Otherwise the FSM goes to the next T.
- Bus exclusivity invariant: popcount(r_out)+g_out+din_out ≤ 1 in every cycle. It equals 1 whenever any of r_in, a_in, g_in, addr_in or dout_in is 1.
- rx = ry is legal. For example, mv R3,R3 asserts r_out[3] and r_in[3] together.
- run is ignored outside T0.

## Timing
- The FSM updates on the rising edge of clock. Datapath registers latch on the falling edge of the same cycle, so every enable and select is stable for a half-period before it is used.
- IR loaded in T0 (falling edge) is valid at the rising edge that enters T1. Decode in T1 uses that value.
- Latency from run sampled high to done: mv/mvi/mvnz/NOP 2 cycles (T0,T1); st 3 cycles; ALU ops and ld 4 cycles.
- Back-to-back: with run held high, the next T0 follows the done cycle immediately, with no bubble.
- Reset: while reset=1, all outputs are forced to 0, including ir_in. At the next edge the state is T0. Reset during T1–T3 aborts the instruction; no r_in, a_in, g_in, dout_in or w_d pulse occurs in the reset cycle or after it.
- After reset, T0 with run=0 keeps every output at 0 indefinitely.

## Test plan
- Reset then idle: reset=1 for 2 cycles, run=0 for 5 cycles -> every output 0, state remains T0.
- mvi R2,#0x00A5 then mv R5,R2: run=1, ir=0x1400 then 0x0A80 -> T1 din_out=1 with r_in=0x04 and done; next T1 r_out=0x04 with r_in=0x20 and done. Total 4 cycles.
- add R1,R3 (ir=0x22C0): T1 r_out=0x02, a_in; T2 r_out=0x08, g_in, alu_op=00; T3 g_out, r_in=0x02, done. Same sequence for slt with alu_op=11.
- ld R4,[R6] / st R4,[R6] (ir=0x6980/0x7980): ld gives T1 addr_in+r_out=0x40, T2 nothing, T3 din_out+r_in=0x10+done; st gives T2 r_out=0x10, dout_in, w_d, done.
- mvnz R0,R7 (ir=0x81C0): with g_nz=0, T1 done only and r_in=0; with g_nz=1, r_out=0x80, r_in=0x01, done.
- Reset in T2 of sub: assert reset during T2 -> g_in=0 that cycle, next state T0, no r_in pulse. The bus-exclusivity assertion holds across a random-opcode run of 1000 instructions.
